// File: rtl/hash_sched_k.sv
// hash_sched_k: SHA-2 round-word sequencer; loads one 16-word block, then streams {W[t], K[t], t} per round.
// Optional feature macro HASH_SCHED_KW_EN adds a registered kw_out = K[t] + W[t].
module hash_sched_k #(
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [WORD_W-1:0] k_out,
    output logic [6:0]        round_out,
`ifdef HASH_SCHED_KW_EN
    output logic [WORD_W-1:0] kw_out,
`endif
    output logic              out_last
);

    localparam int         ROUNDS = (WORD_W == 64) ? 80 : 64;
    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    localparam int S0_A = (WORD_W == 64) ? 1  : 7;
    localparam int S0_B = (WORD_W == 64) ? 8  : 18;
    localparam int S0_C = (WORD_W == 64) ? 7  : 3;
    localparam int S1_A = (WORD_W == 64) ? 19 : 17;
    localparam int S1_B = (WORD_W == 64) ? 61 : 19;
    localparam int S1_C = (WORD_W == 64) ? 6  : 10;

    // SHA-512 constants; SHA-256 mode takes the upper half of each entry.
    localparam logic [63:0] K_TAB [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_cnt;
    logic [6:0]        r_round;
    logic [WORD_W-1:0] r_win [16];
    logic              w_inFire;
    logic              w_outFire;
    logic [WORD_W-1:0] w_newWord;

    if (WORD_W != 32 && WORD_W != 64) begin : g_badWidth
        $error("hash_sched_k: WORD_W must be 32 or 64");
    end

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
    endfunction

    function automatic logic [WORD_W-1:0] kLookup(input logic [6:0] idx);
        if (idx >= 7'(ROUNDS)) return '0;
        return K_TAB[idx][63 -: WORD_W];
    endfunction

    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = out_valid && out_ready;
    assign w_newWord = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    assign in_ready  = (r_state != RUN);
    assign out_valid = (r_state == RUN);
    assign out_last  = out_valid && (r_round == LAST_T);
    assign w_out     = r_win[0];
    assign k_out     = kLookup(r_round);
    assign round_out = r_round;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, LOAD: if (w_inFire) w_nextState = (r_cnt == 4'd15) ? RUN : LOAD;
            RUN:        if (w_outFire && r_round == LAST_T) w_nextState = IDLE;
            default:    w_nextState = IDLE;
        endcase
    end

    // The window is a single shift register: loads push message words, rounds push expanded words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_round <= '0;
            for (int j = 0; j < 16; j++) r_win[j] <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_inFire) r_cnt <= r_cnt + 4'd1;
            if (w_outFire) r_round <= (r_round == LAST_T) ? 7'd0 : r_round + 7'd1;
            if (w_inFire || w_outFire) begin
                for (int j = 0; j < 15; j++) r_win[j] <= r_win[j+1];
                r_win[15] <= w_inFire ? in_word : w_newWord;
            end
        end
    end

`ifdef HASH_SCHED_KW_EN
    logic [WORD_W-1:0] r_kw;

    // Sum for the round that becomes current after this handshake; win[1] is about to become w_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kw <= '0;
        end else if (w_inFire || w_outFire) begin
            r_kw <= kLookup(w_inFire ? 7'd0 : r_round + 7'd1) + r_win[1];
        end
    end

    assign kw_out = r_kw;
`endif

endmodule

// File: tb/tb_hash_sched_k.sv
// tb_hash_sched_k: drives a SHA-256 and a SHA-512 instance of hash_sched_k and compares every
// round triple against a FIPS-style schedule model computed inside the bench.
module tb_hash_sched_k;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  inValid;
    logic [1:0]  outReady;
    logic [1:0]  inReady;
    logic [1:0]  outValid;
    logic [1:0]  outLast;
    logic [63:0] inWord;
    logic [31:0] w32, k32;
    logic [63:0] w64, k64;
    logic [6:0]  r32, r64;
`ifdef HASH_SCHED_KW_EN
    logic [31:0] kw32;
    logic [63:0] kw64;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hash_sched_k #(.WORD_W(32)) u_dut32 (
        .clk(clk), .rst_n(rstN), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_word(inWord[31:0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .w_out(w32), .k_out(k32), .round_out(r32),
`ifdef HASH_SCHED_KW_EN
        .kw_out(kw32),
`endif
        .out_last(outLast[0])
    );

    hash_sched_k #(.WORD_W(64)) u_dut64 (
        .clk(clk), .rst_n(rstN), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_word(inWord), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .w_out(w64), .k_out(k64), .round_out(r64),
`ifdef HASH_SCHED_KW_EN
        .kw_out(kw64),
`endif
        .out_last(outLast[1])
    );

    localparam logic [63:0] KREF [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef struct {
        int          mode;
        int          t;
        bit          chkW;
        logic [63:0] expW;
        logic [63:0] expK;
        bit          expLast;
    } vec_t;

    logic [63:0] msg    [16];
    logic [63:0] modelW [80];
    logic [63:0] obsW   [2][80];
    logic [63:0] obsK   [2][80];
    logic        obsLast[2][80];

    function automatic int rounds(input int m);
        return (m != 0) ? 80 : 64;
    endfunction

    function automatic logic [63:0] mask(input int m, input logic [63:0] x);
        return (m != 0) ? x : {32'h0, x[31:0]};
    endfunction

    function automatic logic [63:0] rotr(input int m, input logic [63:0] x, input int n);
        logic [31:0] v;
        v = x[31:0];
        if (m != 0) return (x >> n) | (x << (64 - n));
        return {32'h0, (v >> n) | (v << (32 - n))};
    endfunction

    function automatic logic [63:0] sig0(input int m, input logic [63:0] x);
        if (m != 0) return rotr(1, x, 1) ^ rotr(1, x, 8) ^ (x >> 7);
        return rotr(0, x, 7) ^ rotr(0, x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] sig1(input int m, input logic [63:0] x);
        if (m != 0) return rotr(1, x, 19) ^ rotr(1, x, 61) ^ (x >> 6);
        return rotr(0, x, 17) ^ rotr(0, x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [63:0] expK(input int m, input int t);
        return (m != 0) ? KREF[t] : {32'h0, KREF[t][63:32]};
    endfunction

    function automatic logic [63:0] curW(input int m);
        return (m != 0) ? w64 : {32'h0, w32};
    endfunction

    function automatic logic [63:0] curK(input int m);
        return (m != 0) ? k64 : {32'h0, k32};
    endfunction

    function automatic logic [63:0] curRound(input int m);
        return (m != 0) ? 64'(r64) : 64'(r32);
    endfunction

`ifdef HASH_SCHED_KW_EN
    function automatic logic [63:0] curKw(input int m);
        return (m != 0) ? kw64 : {32'h0, kw32};
    endfunction
`endif

    // Whole-block schedule from the textbook recurrence on W[t-2], W[t-7], W[t-15], W[t-16].
    task automatic buildModel(input int m);
        for (int t = 0; t < 80; t++) begin
            if (t < 16) modelW[t] = mask(m, msg[t]);
            else modelW[t] = mask(m, sig1(m, modelW[t-2]) + modelW[t-7]
                                     + sig0(m, modelW[t-15]) + modelW[t-16]);
        end
    endtask

    task automatic randomMsg();
        for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input bit holdValid, output int cycles);
        cycles = 0;
        for (int i = 0; i < 16; i++) begin
            inWord     = mask(m, msg[i]);
            inValid[m] = 1'b1;
            while (!inReady[m] && cycles < 300) begin
                @(negedge clk);
                cycles++;
            end
            @(negedge clk);
            cycles++;
        end
        if (holdValid) inWord = {$urandom, $urandom};
        else inValid[m] = 1'b0;
    endtask

    task automatic collectRounds(input int m, input int limit, input bit stall);
        int          count = 0;
        int          cycles = 0;
        bit          held = 0;
        logic [63:0] snapW, snapK, snapR;
        while (count < limit && cycles < 1000) begin
            if (held) begin
                checkOutput("stall_valid", 64'(outValid[m]), 64'd1);
                checkOutput("stall_w", curW(m), snapW);
                checkOutput("stall_k", curK(m), snapK);
                checkOutput("stall_round", curRound(m), snapR);
            end
            outReady[m] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 0;
            if (outValid[m]) begin
                if (outReady[m]) begin
                    obsW[m][count]    = curW(m);
                    obsK[m][count]    = curK(m);
                    obsLast[m][count] = outLast[m];
                    checkOutput($sformatf("w_m%0d_t%0d", m, count), curW(m), modelW[count]);
                    checkOutput($sformatf("k_m%0d_t%0d", m, count), curK(m), expK(m, count));
                    checkOutput($sformatf("round_m%0d", m), curRound(m), 64'(count));
                    checkOutput($sformatf("last_m%0d_t%0d", m, count), 64'(outLast[m]),
                                64'(count == rounds(m) - 1));
`ifdef HASH_SCHED_KW_EN
                    checkOutput($sformatf("kw_m%0d_t%0d", m, count), curKw(m),
                                mask(m, expK(m, count) + modelW[count]));
`endif
                    count++;
                end else begin
                    snapW = curW(m);
                    snapK = curK(m);
                    snapR = curRound(m);
                    held  = 1;
                end
            end
            @(negedge clk);
            cycles++;
        end
        outReady[m] = 1'b0;
        if (count < limit) checkOutput("collect_timeout", 64'(count), 64'(limit));
    endtask

    task automatic checkEnd(input int m);
        checkOutput($sformatf("end_valid_m%0d", m), 64'(outValid[m]), 64'd0);
        checkOutput($sformatf("end_ready_m%0d", m), 64'(inReady[m]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [10];
        int   lc;

        vecs[0] = '{0, 0,  1'b1, 64'h61626380,         64'h428a2f98,         1'b0};
        vecs[1] = '{0, 16, 1'b1, 64'h61626380,         64'he49b69c1,         1'b0};
        vecs[2] = '{0, 17, 1'b1, 64'h000f0000,         64'hefbe4786,         1'b0};
        vecs[3] = '{0, 62, 1'b0, 64'h0,                64'hbef9a3f7,         1'b0};
        vecs[4] = '{0, 63, 1'b0, 64'h0,                64'hc67178f2,         1'b1};
        vecs[5] = '{1, 0,  1'b1, 64'h6162638000000000, 64'h428a2f98d728ae22, 1'b0};
        vecs[6] = '{1, 15, 1'b1, 64'h18,               64'hc19bf174cf692694, 1'b0};
        vecs[7] = '{1, 16, 1'b1, 64'h6162638000000000, 64'he49b69c19ef14ad2, 1'b0};
        vecs[8] = '{1, 78, 1'b0, 64'h0,                64'h5fcb6fab3ad6faec, 1'b0};
        vecs[9] = '{1, 79, 1'b0, 64'h0,                64'h6c44198c4a475817, 1'b1};

        // Reset held for two edges with in_valid asserted on both instances.
        rstN     = 1'b0;
        inValid  = 2'b11;
        outReady = 2'b00;
        inWord   = {$urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("rst_ready_m%0d", m), 64'(inReady[m]), 64'd1);
            checkOutput($sformatf("rst_valid_m%0d", m), 64'(outValid[m]), 64'd0);
            checkOutput($sformatf("rst_round_m%0d", m), curRound(m), 64'd0);
            checkOutput($sformatf("rst_w_m%0d", m), curW(m), 64'd0);
`ifdef HASH_SCHED_KW_EN
            checkOutput($sformatf("rst_kw_m%0d", m), curKw(m), 64'd0);
`endif
        end
        inValid = 2'b00;
        rstN    = 1'b1;
        @(negedge clk);

        // "abc" block in both widths, then the constant/boundary table.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) msg[i] = 64'h0;
            msg[0]  = (m != 0) ? 64'h6162638000000000 : 64'h61626380;
            msg[15] = 64'h18;
            buildModel(m);
            applyStimulus(m, 1'b0, lc);
            checkOutput($sformatf("load_cycles_m%0d", m), 64'(lc), 64'd16);
            checkOutput($sformatf("latency_valid_m%0d", m), 64'(outValid[m]), 64'd1);
            collectRounds(m, rounds(m), 1'b0);
            checkEnd(m);
        end
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].chkW)
                checkOutput($sformatf("tbl_w_m%0d_t%0d", vecs[v].mode, vecs[v].t),
                            obsW[vecs[v].mode][vecs[v].t], vecs[v].expW);
            checkOutput($sformatf("tbl_k_m%0d_t%0d", vecs[v].mode, vecs[v].t),
                        obsK[vecs[v].mode][vecs[v].t], vecs[v].expK);
            checkOutput($sformatf("tbl_last_m%0d_t%0d", vecs[v].mode, vecs[v].t),
                        64'(obsLast[vecs[v].mode][vecs[v].t]), 64'(vecs[v].expLast));
        end

        // Random blocks with random output stalls.
        for (int m = 0; m < 2; m++) begin
            randomMsg();
            buildModel(m);
            applyStimulus(m, 1'b0, lc);
            collectRounds(m, rounds(m), 1'b1);
            checkEnd(m);
        end

        // Back-to-back blocks with in_valid held high through RUN.
        randomMsg();
        buildModel(0);
        applyStimulus(0, 1'b1, lc);
        collectRounds(0, 64, 1'b0);
        checkOutput("b2b_ready", 64'(inReady[0]), 64'd1);
        randomMsg();
        buildModel(0);
        applyStimulus(0, 1'b0, lc);
        checkOutput("b2b_load_cycles", 64'(lc), 64'd16);
        collectRounds(0, 64, 1'b1);
        checkEnd(0);

        // Reset in the middle of RUN, then a fresh block.
        randomMsg();
        buildModel(1);
        applyStimulus(1, 1'b0, lc);
        collectRounds(1, 30, 1'b0);
        checkOutput("mid_round", curRound(1), 64'd30);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("mid_rst_valid", 64'(outValid[1]), 64'd0);
        checkOutput("mid_rst_ready", 64'(inReady[1]), 64'd1);
        checkOutput("mid_rst_round", curRound(1), 64'd0);
        checkOutput("mid_rst_w", curW(1), 64'd0);
        @(negedge clk);
        checkOutput("mid_rst_stay_idle", 64'(outValid[1]), 64'd0);
        randomMsg();
        buildModel(1);
        applyStimulus(1, 1'b0, lc);
        collectRounds(1, 80, 1'b0);
        checkEnd(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
